// File: rtl/tt_pkg.sv
// Shared types and defaults for the TT initiator: station width, buffer depth,
// response timeout and the transaction state encoding.
package tt_pkg;

  localparam int STN_W     = 4;
  localparam int ENTRY_W   = 2 * STN_W;
  localparam int DEPTH_DEF = 16;
  localparam int TMO_DEF   = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_Q,
    S_SEND_E,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [STN_W-1:0] src;
    logic [STN_W-1:0] dst;
  } edge_t;

endpackage

// File: rtl/tt_edge_fifo.sv
// Edge buffer: DEPTH-entry FIFO of packed (src,dst) pairs with occupancy count.
// A push into a full buffer or a pop from an empty one is dropped.
module tt_edge_fifo
  import tt_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/tt_initiator.sv
// TT initiator: buffers track edges from the host, launches a query followed by
// the buffered edges on the TT request channel, then waits for a cost or times out.
module tt_initiator
  import tt_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  input  logic [STN_W-1:0] ld_src,
  input  logic [STN_W-1:0] ld_dst,
  output logic             ld_ready,
  input  logic             start,
  input  logic [STN_W-1:0] q_src,
  input  logic [STN_W-1:0] q_dst,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result_cost,
  output logic             timeout,
  output logic             in_valid,
  output logic [STN_W-1:0] source,
  output logic [STN_W-1:0] destination,
  input  logic             out_valid,
  input  logic [3:0]       cost
);

  localparam int         CNT_W    = $clog2(DEPTH + 1);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               in_valid_q, in_valid_d;
  logic [STN_W-1:0]   source_q, source_d;
  logic [STN_W-1:0]   destination_q, destination_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [3:0]         result_cost_q, result_cost_d;

  logic               push, pop, fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_rd_raw;
  edge_t              fifo_rd, ld_edge;

  assign ld_ready = (state_q == S_IDLE) && !fifo_full && !start;
  assign push     = ld_valid && ld_ready;
  assign ld_edge  = '{src: ld_src, dst: ld_dst};
  assign fifo_rd  = edge_t'(fifo_rd_raw);

  tt_edge_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (ld_edge),
    .pop     (pop),
    .rd_data (fifo_rd_raw),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  // Outputs are computed for the state being entered, so each beat appears in the cycle its state is current.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d       = state_q;
    rem_d         = rem_q;
    tmo_cnt_d     = tmo_cnt_q;
    in_valid_d    = 1'b0;
    source_d      = '0;
    destination_d = '0;
    done_d        = 1'b0;
    timeout_d     = timeout_q;
    result_cost_d = result_cost_q;
    pop           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_SEND_Q;
          in_valid_d    = 1'b1;
          source_d      = q_src;
          destination_d = q_dst;
          rem_d         = fifo_count;
          result_cost_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_SEND_Q, S_SEND_E: begin
        if (rem_q != '0) begin
          state_d       = S_SEND_E;
          pop           = 1'b1;
          in_valid_d    = 1'b1;
          source_d      = fifo_rd.src;
          destination_d = fifo_rd.dst;
          rem_d         = rem_q - CNT_W'(1);
        end else begin
          state_d   = S_WAIT;
          tmo_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (out_valid) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          result_cost_d = cost;
          timeout_d     = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          result_cost_d = '0;
          timeout_d     = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        tmo_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      tmo_cnt_q     <= '0;
      in_valid_q    <= 1'b0;
      source_q      <= '0;
      destination_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      result_cost_q <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      tmo_cnt_q     <= tmo_cnt_d;
      in_valid_q    <= in_valid_d;
      source_q      <= source_d;
      destination_q <= destination_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      result_cost_q <= result_cost_d;
    end
  end

  assign in_valid    = in_valid_q;
  assign source      = source_q;
  assign destination = destination_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign result_cost = result_cost_q;

endmodule

// File: tb/tb_tt_initiator.sv
// Directed bench for tt_initiator: edge loading, launch sequencing, response,
// timeout, buffer-full back-pressure and mid-transaction reset.
module tb_tt_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_valid;
  logic [3:0] ld_src, ld_dst;
  logic       ld_ready;
  logic       start;
  logic [3:0] q_src, q_dst;
  logic       busy, done, timeout;
  logic [3:0] result_cost;
  logic       in_valid;
  logic [3:0] source, destination;
  logic       out_valid;
  logic [3:0] cost;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tt_initiator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_src      (ld_src),
    .ld_dst      (ld_dst),
    .ld_ready    (ld_ready),
    .start       (start),
    .q_src       (q_src),
    .q_dst       (q_dst),
    .busy        (busy),
    .done        (done),
    .result_cost (result_cost),
    .timeout     (timeout),
    .in_valid    (in_valid),
    .source      (source),
    .destination (destination),
    .out_valid   (out_valid),
    .cost        (cost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [3:0] s, input logic [3:0] d);
    check({tag, ".in_valid"}, 32'(in_valid), 32'd1);
    check({tag, ".source"}, 32'(source), 32'(s));
    check({tag, ".destination"}, 32'(destination), 32'(d));
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, ".in_valid"}, 32'(in_valid), 32'd0);
    check({tag, ".source"}, 32'(source), 32'd0);
    check({tag, ".destination"}, 32'(destination), 32'd0);
  endtask

  task automatic load(input logic [3:0] s, input logic [3:0] d);
    ld_valid = 1'b1;
    ld_src   = s;
    ld_dst   = d;
    check("load.ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // After this returns the bench sits in cycle T+1 (the query beat).
  task automatic launch(input logic [3:0] s, input logic [3:0] d);
    start = 1'b1;
    q_src = s;
    q_dst = d;
    @(negedge clk);
    start = 1'b0;
    q_src = 4'h0;
    q_dst = 4'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [3:0] es, ed;

    rst_n = 1'b0; ld_valid = 1'b0; ld_src = 4'h0; ld_dst = 4'h0;
    start = 1'b0; q_src = 4'h0; q_dst = 4'h0; out_valid = 1'b0; cost = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result_cost", 32'(result_cost), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    check_idle_bus("rst");
    rst_n = 1'b1;

    // Two edges, query (1,5); a stray response during SEND_Q must be ignored.
    load(4'd1, 4'd2);
    load(4'd2, 4'd5);
    launch(4'd1, 4'd5);
    check_beat("t1.q", 4'd1, 4'd5);
    check("t1.busy", 32'(busy), 32'd1);
    check("t1.ld_ready_busy", 32'(ld_ready), 32'd0);
    out_valid = 1'b1; cost = 4'd9;
    @(negedge clk);
    out_valid = 1'b0; cost = 4'd0;
    check_beat("t1.e0", 4'd1, 4'd2);
    check("t1.no_early_done", 32'(done), 32'd0);
    @(negedge clk);
    check_beat("t1.e1", 4'd2, 4'd5);
    @(negedge clk);
    check_idle_bus("t1.wait");
    check("t1.wait_done", 32'(done), 32'd0);
    out_valid = 1'b1; cost = 4'd2;
    @(negedge clk);
    out_valid = 1'b0; cost = 4'd0;
    check("t1.done", 32'(done), 32'd1);
    check("t1.result_cost", 32'(result_cost), 32'd2);
    check("t1.timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    check("t1.done_pulse", 32'(done), 32'd0);
    check("t1.busy_after", 32'(busy), 32'd0);
    check("t1.result_hold", 32'(result_cost), 32'd2);

    // Response in IDLE is ignored.
    out_valid = 1'b1; cost = 4'd7;
    @(negedge clk);
    out_valid = 1'b0; cost = 4'd0;
    check("idle.done", 32'(done), 32'd0);
    check("idle.result_hold", 32'(result_cost), 32'd2);

    // Empty buffer: single query beat, then zero cost returned.
    launch(4'd3, 4'd3);
    check_beat("t2.q", 4'd3, 4'd3);
    check("t2.result_cleared", 32'(result_cost), 32'd0);
    @(negedge clk);
    check_idle_bus("t2.wait");
    out_valid = 1'b1; cost = 4'd0;
    @(negedge clk);
    out_valid = 1'b0;
    check("t2.done", 32'(done), 32'd1);
    check("t2.result_cost", 32'(result_cost), 32'd0);
    check("t2.timeout", 32'(timeout), 32'd0);
    @(negedge clk);

    // Fill the buffer; the 17th offer is refused and not stored.
    for (int i = 0; i < 16; i++) begin
      es = 4'(i);
      ed = 4'(15 - i);
      load(es, ed);
    end
    ld_valid = 1'b1; ld_src = 4'd9; ld_dst = 4'd9;
    check("t3.ld_ready_full", 32'(ld_ready), 32'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    check("t3.count_full", 32'(dut.u_fifo.count), 32'd16);
    launch(4'd4, 4'd7);
    check_beat("t3.q", 4'd4, 4'd7);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      es = 4'(i);
      ed = 4'(15 - i);
      check_beat($sformatf("t3.e%0d", i), es, ed);
    end
    @(negedge clk);
    check_idle_bus("t3.wait");
    check("t3.count_empty", 32'(dut.u_fifo.count), 32'd0);

    // No response: done with timeout exactly 255 cycles after entering WAIT.
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t4.tmo_cycles", 32'(k), 32'd255);
    check("t4.done", 32'(done), 32'd1);
    check("t4.timeout", 32'(timeout), 32'd1);
    check("t4.result_cost", 32'(result_cost), 32'd0);
    @(negedge clk);
    check("t4.timeout_hold", 32'(timeout), 32'd1);

    // Reset asserted mid-SEND_E takes effect immediately.
    load(4'd1, 4'd1);
    load(4'd2, 4'd2);
    load(4'd3, 4'd3);
    launch(4'd6, 4'd6);
    @(negedge clk);
    check_beat("t5.e0", 4'd1, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_bus("t5.rst");
    check("t5.busy", 32'(busy), 32'd0);
    check("t5.count", 32'(dut.u_fifo.count), 32'd0);
    check("t5.timeout", 32'(timeout), 32'd0);
    check("t5.result_cost", 32'(result_cost), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Operation resumes on the first edge after reset release.
    load(4'd8, 4'd9);
    check("t6.count", 32'(dut.u_fifo.count), 32'd1);
    launch(4'd8, 4'd8);
    check_beat("t6.q", 4'd8, 4'd8);
    @(negedge clk);
    check_beat("t6.e0", 4'd8, 4'd9);
    @(negedge clk);
    check_idle_bus("t6.wait");
    out_valid = 1'b1; cost = 4'd5;
    @(negedge clk);
    out_valid = 1'b0; cost = 4'd0;
    check("t6.done", 32'(done), 32'd1);
    check("t6.result_cost", 32'(result_cost), 32'd5);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_initiator.md
TT_INITIATOR -- requirements
Module: tt_initiator

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ld_valid  input  1  host offers one track edge.
REQ-004 SHALL have port ld_src  input  4  edge start station.
REQ-005 SHALL have port ld_dst  input  4  edge end station.
REQ-006 SHALL have port ld_ready  output  1  edge accepted when ld_valid && ld_ready.
REQ-007 SHALL have port start  input  1  launch one TT transaction.
REQ-008 SHALL have port q_src  input  4  query start station, sampled with start.
REQ-009 SHALL have port q_dst  input  4  query target station, sampled with start.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result_cost  output  4  cost returned by responder.
REQ-013 SHALL have port timeout  output  1  qualifies done: no response received.
REQ-014 SHALL have port in_valid  output  1  TT request beat valid.
REQ-015 SHALL have port source  output  4  TT request source field.
REQ-016 SHALL have port destination  output  4  TT request destination field.
REQ-017 SHALL have port out_valid  input  1  TT response valid.
REQ-018 SHALL have port cost  input  4  TT response cost.
REQ-019 SHALL have parameters DEPTH, default 16, edge buffer entries; TMO, default 255, response timeout in cycles.

Function
REQ-020 SHALL implement FSM IDLE -> SEND_Q -> SEND_E -> WAIT -> DONE -> IDLE.
REQ-021 SHALL buffer edges in a DEPTH-entry FIFO; ld_ready = (state==IDLE) && !full && !start.
REQ-022 SHALL on start in IDLE at cycle T latch q_src/q_dst and edge count N (0..DEPTH); start outside IDLE ignored.
REQ-023 SHALL drive in_valid=1 with source=q_src, destination=q_dst at T+1 (SEND_Q).
REQ-024 SHALL drive edges in FIFO order at T+2..T+1+N, one per cycle, popping each (SEND_E); N=0 skips SEND_E.
REQ-025 SHALL drive in_valid=0 from T+2+N; source/destination SHALL be 0 whenever in_valid=0.
REQ-026 SHALL ignore out_valid in any state other than WAIT.
REQ-027 SHALL in WAIT on out_valid capture cost into result_cost and pulse done, timeout=0, next cycle (DONE).
REQ-028 SHALL count WAIT cycles with an 8-bit counter; after TMO cycles without out_valid, enter DONE with result_cost=0, timeout=1.
REQ-029 SHALL hold result_cost and timeout stable from DONE until the next accepted start.
REQ-030 SHALL leave the FIFO empty after launch; a full FIFO SHALL deassert ld_ready, never overwrite.
REQ-031 SHALL drive all TT outputs from flops (no combinational path from host inputs).

Reset
REQ-032 SHALL on rst_n low, at any time including mid-transaction, immediately force: state IDLE, FIFO empty, in_valid=0, source=0, destination=0, busy=0, done=0, result_cost=0, timeout=0, counter=0.
REQ-033 SHALL accept loads/start the first rising edge after rst_n deasserts.

Structure
REQ-034 SHALL place state enum, STN_W=4, DEPTH and TMO defaults in shared package tt_pkg.
REQ-035 SHALL implement the edge buffer as sub-module tt_edge_fifo (8-bit entries, push/pop/count).

Verification
REQ-036 Load edges (1,2),(2,5); start q=(1,5) -> in_valid beats (1,5),(1,2),(2,5), then low; out_valid cost=2 -> done=1, result_cost=2, timeout=0.
REQ-037 Empty FIFO, start q=(3,3) -> exactly one in_valid beat (3,3); cost=0 returned -> done, result_cost=0.
REQ-038 Load 16 edges -> ld_ready=0 on 17th offer, 17th not stored; launch sends 16 edge beats.
REQ-039 Start, no out_valid -> done with timeout=1, result_cost=0 exactly TMO cycles after entering WAIT.
REQ-040 Assert rst_n low during SEND_E -> in_valid=0 same cycle, busy=0, FIFO count=0; stray out_valid during SEND ignored.
